// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings, SRAM slave FSM states and byte-lane helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } sram_state_t;

  // Byte lanes touched by a transfer of the given size at byte offset a.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << a;
      HSIZE_HALF: lane_mask = 4'b0011 << a;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the bridge (master) and the SRAM slave.
interface ahb_sram_slave_if;

  logic [31:0] h_addr;
  logic [2:0]  h_burst;
  logic [2:0]  h_size;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;
  logic [31:0] h_rdata;
  logic        h_ready;
  logic        h_resp;

  modport master (
    output h_addr, h_burst, h_size, h_trans, h_write, h_wdata, h_wstrb,
    input  h_rdata, h_ready, h_resp
  );

  modport slave (
    input  h_addr, h_burst, h_size, h_trans, h_write, h_wdata, h_wstrb,
    output h_rdata, h_ready, h_resp
  );

endinterface

// File: rtl/ahb_sram_slave_ram.sv
// Single-port DEPTH x 32 SRAM with per-byte write enables and asynchronous read.
module sp_ram_be #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-wide SRAM; two-cycle ERROR on illegal beats.
// Define AHB_SRAM_WAIT_EN to insert WAIT_CYCLES wait states per NONSEQ/SEQ beat.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             h_clk,
  input  logic             h_reset,
  ahb_sram_slave_if.slave  bus
);

`ifdef AHB_SRAM_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam bit WAIT_ON = 1'b0;
`endif

  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  sram_state_t   state_q, state_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;

  logic          ready, resp;
  logic          capture, legal, in_range, aligned;
  logic [31:0]   offset;
  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic [3:0]    ram_be;

  assign offset   = bus.h_addr - BASE_ADDR;
  assign in_range = (bus.h_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  always_comb begin
    case (bus.h_size)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~bus.h_addr[0];
      HSIZE_WORD: aligned = (bus.h_addr[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  assign legal   = in_range && aligned;
  assign capture = ready && bus.h_trans[1];

  always_comb begin
    ready = 1'b1;
    resp  = HRESP_OKAY;
    case (state_q)
      ST_WAIT: ready = 1'b0;
      ST_ERR1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
      end
      ST_ERR2: resp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
`ifdef AHB_SRAM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_WAIT: begin
`ifdef AHB_SRAM_WAIT_EN
        if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = ST_ACCESS;
`endif
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, ACCESS and ERR2 all leave the address phase open
        if (capture) begin
          word_d  = offset[AW+1:2];
          lane_d  = bus.h_addr[1:0];
          size_d  = bus.h_size;
          write_d = bus.h_write;
          if (!legal)                             state_d = ST_ERR1;
          else if (WAIT_ON && (WAIT_CYCLES != 0)) state_d = ST_WAIT;
          else                                    state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ram_we = (state_q == ST_ACCESS) && write_q;
  assign ram_be = bus.h_wstrb & lane_mask(size_q, lane_q);

  sp_ram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (h_clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (word_q),
    .wdata_i (bus.h_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.h_ready = ready;
  assign bus.h_resp  = resp;
  assign bus.h_rdata = ((state_q == ST_ACCESS) && !write_q) ? ram_rdata : '0;

endmodule
